fifo_read_master: RTL and testbench

FIFO_READ_MASTER -- requirements
Module: fifo_read_master

---
 rtl/fifo_read_master_if.sv | 26 ++
 rtl/fifo_read_master.sv | 88 ++++++++
 tb/tb_fifo_read_master.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_master_if.sv
// Read-side bundle for fifo_read_master: FIFO pop port, downstream valid/ready
// stream, run request and status.
interface fifo_read_master_if #(
  parameter int DSIZE  = 8,
  parameter int CWIDTH = 16
);
  logic              en;
  logic              rempty;
  logic [DSIZE-1:0]  rdata;
  logic              rinc;
  logic [DSIZE-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CWIDTH-1:0] rd_count;
  logic              busy;

  modport master (
    input  en, rempty, rdata, out_ready,
    output rinc, out_data, out_valid, rd_count, busy
  );

  modport slave (
    output en, rempty, rdata, out_ready,
    input  rinc, out_data, out_valid, rd_count, busy
  );
endinterface

// File: rtl/fifo_read_master.sv
// Pops words from a FIFO read port into a 2-entry skid buffer and presents
// them as a registered valid/ready stream. Popping is gated by a small
// IDLE/RUN/DRAIN controller so that dropping en lets buffered words drain.
module fifo_read_master #(
  parameter int DSIZE  = 8,
  parameter int CWIDTH = 16
) (
  input logic                rclk,
  input logic                rrst,
  fifo_read_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        cnt;
  logic [1:0]        cnt_next;
  logic              rptr;
  logic              wptr;
  logic              push;
  logic              xfer;
  logic              valid;
  logic [DSIZE-1:0]  mem [2];
  logic [CWIDTH-1:0] rd_count;

  // Output side is driven purely from registered buffer state, never from rdata.
  assign valid         = (cnt != 2'd0);
  assign xfer          = valid & bus.out_ready;
  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? mem[rptr] : '0;
  assign bus.rinc      = push;
  assign bus.rd_count  = rd_count;
  assign bus.busy      = (state != IDLE) | valid;

  // Pop decision, occupancy update and next-state selection.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    if (state == RUN) begin
      // A full buffer may only accept a word when one leaves in the same cycle.
      push = !bus.rempty && !rrst && ((cnt < 2'd2) || xfer);
    end
    cnt_next = cnt + {1'b0, push} - {1'b0, xfer};
    case (state)
      IDLE:    if (bus.en) state_next = RUN;
      RUN:     if (!bus.en) state_next = DRAIN;
      DRAIN: begin
        if (bus.en)                state_next = RUN;
        else if (cnt_next == 2'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge rclk) begin
    if (rrst) state <= IDLE;
    else      state <= state_next;
  end

  // Buffer occupancy, pointers and pop counter; reset discards buffered words.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt      <= 2'd0;
      rptr     <= 1'b0;
      wptr     <= 1'b0;
      rd_count <= '0;
    end else begin
      cnt <= cnt_next;
      if (push) begin
        wptr     <= ~wptr;
        rd_count <= rd_count + 1'b1;
      end
      if (xfer) rptr <= ~rptr;
    end
  end

  // Buffer storage; contents are only meaningful while counted by cnt.
  always_ff @(posedge rclk) begin
    if (push) mem[wptr] <= bus.rdata;
  end

endmodule

// File: tb/tb_fifo_read_master.sv
// Bench for fifo_read_master: a FIFO emulation feeds the DUT, a queue-based
// reference model is compared every cycle, and directed scenarios pin
// hand-computed results.
module tb_fifo_read_master;
  localparam int DSIZE  = 8;
  localparam int CWIDTH = 4;
  localparam int IDLE_S = 0, RUN_S = 1, DRAIN_S = 2;

  logic rclk = 1'b0;
  logic rrst;
  always #5 rclk = ~rclk;

  fifo_read_master_if #(.DSIZE(DSIZE), .CWIDTH(CWIDTH)) bus ();

  fifo_read_master #(.DSIZE(DSIZE), .CWIDTH(CWIDTH)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [7:0] fifo_q [$];
  logic [7:0] mq [$];
  logic [7:0] got [$];
  int   mst    = IDLE_S;
  int   mcount = 0;
  bit   pop_pend = 1'b0;
  bit   e_valid, e_rinc;
  logic [7:0] e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO emulation, per-cycle comparison against the model, then model step.
  always @(negedge rclk) begin
    if (pop_pend && fifo_q.size() > 0) fifo_q.delete(0);
    pop_pend   = 1'b0;
    bus.rempty = (fifo_q.size() == 0);
    bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    #1;
    e_valid = (mq.size() != 0);
    e_data  = e_valid ? mq[0] : 8'h00;
    e_rinc  = (mst == RUN_S) && (fifo_q.size() != 0) && !rrst &&
              ((mq.size() < 2) || (e_valid && bus.out_ready));
    chk("rinc", bus.rinc, e_rinc);
    chk("out_valid", bus.out_valid, e_valid);
    chk("out_data", bus.out_data, e_data);
    chk("busy", bus.busy, (mst != IDLE_S) || e_valid);
    chk("rd_count", bus.rd_count, mcount);
    if (bus.out_valid && bus.out_ready && !rrst) got.push_back(bus.out_data);
    pop_pend = bus.rinc;
    if (bus.rinc) pops++;
    if (rrst) begin
      mq.delete();
      mcount = 0;
      mst    = IDLE_S;
    end else begin
      if (e_valid && bus.out_ready) mq.delete(0);
      if (e_rinc) begin
        mq.push_back(fifo_q[0]);
        mcount = (mcount + 1) % (1 << CWIDTH);
      end
      case (mst)
        IDLE_S:  if (bus.en) mst = RUN_S;
        RUN_S:   if (!bus.en) mst = DRAIN_S;
        default: begin
          if (bus.en)              mst = RUN_S;
          else if (mq.size() == 0) mst = IDLE_S;
        end
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic wait_got(input int n, input int limit, input string name);
    int c = 0;
    while (got.size() < n && c < limit) begin
      tick(1);
      c++;
    end
    chk(name, (got.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rrst          = 1'b1;
    bus.en        = 1'b0;
    bus.out_ready = 1'b0;
    tick(2);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_rinc", bus.rinc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_count", bus.rd_count, 0);
    chk("rst_out_data", bus.out_data, 0);

    // Basic in-order stream with first-pop latency after reset.
    rrst = 1'b0;
    bus.en = 1'b1;
    bus.out_ready = 1'b1;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    #1;
    chk("first_edge_rinc", bus.rinc, 0);
    tick(1);
    chk("run_rinc", bus.rinc, 1);
    wait_got(3, 20, "basic_timeout");
    chk("basic_w0", got[0], 8'h11);
    chk("basic_w1", got[1], 8'h22);
    chk("basic_w2", got[2], 8'h33);
    chk("basic_count", bus.rd_count, 3);
    tick(2);
    chk("empty_busy", bus.busy, 1);
    chk("empty_valid", bus.out_valid, 0);
    chk("empty_rinc", bus.rinc, 0);

    // Backpressure: exactly two pops, head held, then one pop per cycle.
    got.delete();
    bus.out_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 5; i++) fifo_q.push_back(8'hA0 + 8'(i));
    tick(6);
    chk("bp_pops", pops - p0, 2);
    chk("bp_rinc", bus.rinc, 0);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_data", bus.out_data, 8'hA1);
    tick(3);
    chk("bp_hold", bus.out_data, 8'hA1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_resume_rinc", bus.rinc, 1);
    wait_got(5, 20, "bp_timeout");
    for (int i = 0; i < 5; i++) chk("bp_order", got[i], 8'hA1 + 8'(i));
    chk("bp_total_pops", pops - p0, 5);

    // Drop en with a full buffer, drain to IDLE, then re-run from DRAIN.
    got.delete();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) fifo_q.push_back(8'hB0 + 8'(i));
    tick(5);
    bus.en = 1'b0;
    #1;
    chk("drop_rinc", bus.rinc, 0);
    tick(2);
    chk("drain_busy", bus.busy, 1);
    bus.out_ready = 1'b1;
    wait_got(2, 10, "drain_timeout");
    tick(2);
    chk("drain_idle_busy", bus.busy, 0);
    chk("drain_w0", got[0], 8'hB1);
    chk("drain_w1", got[1], 8'hB2);
    bus.out_ready = 1'b0;
    bus.en = 1'b1;
    tick(5);
    fifo_q.push_back(8'hC1);
    bus.en = 1'b0;
    tick(2);
    chk("drain2_busy", bus.busy, 1);
    chk("drain2_rinc", bus.rinc, 0);
    bus.en = 1'b1;
    tick(1);
    bus.out_ready = 1'b1;
    wait_got(5, 20, "rerun_timeout");
    chk("rerun_w2", got[2], 8'hB3);
    chk("rerun_w3", got[3], 8'hB4);
    chk("rerun_w4", got[4], 8'hC1);

    // Reset mid-stream with a full buffer; FIFO contents survive.
    got.delete();
    bus.out_ready = 1'b0;
    fifo_q.push_back(8'hD1); fifo_q.push_back(8'hD2); fifo_q.push_back(8'hD3);
    tick(5);
    rrst = 1'b1;
    #1;
    chk("rst_mid_rinc", bus.rinc, 0);
    tick(1);
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_count", bus.rd_count, 0);
    chk("rst_mid_busy", bus.busy, 0);
    rrst = 1'b0;
    bus.out_ready = 1'b1;
    wait_got(1, 10, "rst_mid_timeout");
    chk("rst_mid_survivor", got[0], 8'hD3);
    tick(2);
    chk("rst_mid_count2", bus.rd_count, 1);

    // Counter wrap: 17 pops on a 4-bit counter reads 1.
    rrst = 1'b1;
    tick(1);
    rrst = 1'b0;
    got.delete();
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'h40 + 8'(i));
    wait_got(17, 60, "wrap_timeout");
    tick(2);
    chk("wrap_count", bus.rd_count, 1);
    for (int i = 0; i < 17; i++) chk("wrap_order", got[i], 8'h40 + 8'(i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
